// File: rtl/fetch_ctrl_pkg.sv
// Shared configuration for the instruction-fetch slice: widths, vectors and
// the fetch sequencer state encoding.
package fetch_ctrl_pkg;

    localparam int          DATA_WIDTH   = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;

    typedef enum logic [2:0] {
        FETCH_BOOT,
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_HOLD,
        FETCH_DISCARD
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry skid buffer (instruction + PC) between instruction memory and decode.
// Valid/ready: a transfer happens on any edge where out_valid_o and out_ready_i are both 1.
module fetch_buffer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic [DATA_WIDTH-1:0] push_pc_i,
    output logic                  can_accept_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [DATA_WIDTH-1:0] out_pc_o,
    input  logic                  out_ready_i
);

    logic                  main_valid_q, main_valid_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
    logic [DATA_WIDTH-1:0] main_pc_q, main_pc_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [DATA_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic                  pop;

    assign pop          = main_valid_q && out_ready_i;
    // A push lands in the main slot only when that slot is free by the edge.
    assign can_accept_o = !main_valid_q || (pop && !skid_valid_q);

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_pc_d    = main_pc_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_pc_d    = skid_pc_q;
        if (pop) begin
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                main_pc_d    = skid_pc_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = 1'b0;
            end
        end
        if (push_i) begin
            if (can_accept_o) begin
                main_valid_d = 1'b1;
                main_data_d  = push_data_i;
                main_pc_d    = push_pc_i;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = push_data_i;
                skid_pc_d    = push_pc_i;
            end
        end
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_pc_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_pc_q    <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_pc_q    <= main_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;
    assign out_pc_o    = main_pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, single-outstanding imem requests, redirects.
// Optional misaligned-target trap enabled by defining FETCH_CTRL_MISALIGN_TRAP_EN.
module fetch_ctrl #(
    parameter int                    DATA_WIDTH   = fetch_ctrl_pkg::DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = fetch_ctrl_pkg::RESET_VECTOR,
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = fetch_ctrl_pkg::TRAP_VECTOR
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] instr_pc_o,
    input  logic                  instr_ready_i,
    input  logic                  branch_take_i,
    input  logic [DATA_WIDTH-1:0] branch_target_i,
    output logic                  flush_o,
    output logic                  misalign_o,
    output logic [DATA_WIDTH-1:0] misalign_tval_o
);
    import fetch_ctrl_pkg::*;

    fetch_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  flush_q;
    logic                  push;
    logic                  can_accept;

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    logic                  misaligned;
    logic                  misalign_q;
    logic [DATA_WIDTH-1:0] tval_q;

    assign misaligned  = branch_target_i[1:0] != 2'b00;
    assign redirect_pc = misaligned ? TRAP_VECTOR : branch_target_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            misalign_q <= 1'b0;
            tval_q     <= '0;
        end else begin
            misalign_q <= branch_take_i && misaligned;
            if (branch_take_i && misaligned) begin
                tval_q <= branch_target_i;
            end
        end
    end

    assign misalign_o      = misalign_q;
    assign misalign_tval_o = tval_q;
`else
    logic unused_trap_vector;

    assign unused_trap_vector = ^TRAP_VECTOR;
    assign redirect_pc        = branch_target_i & ~DATA_WIDTH'(3);
    assign misalign_o         = 1'b0;
    assign misalign_tval_o    = '0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        imem_req_o = 1'b0;
        push       = 1'b0;
        case (state_q)
            FETCH_BOOT: state_d = FETCH_REQ;
            FETCH_REQ: begin
                imem_req_o = 1'b1;
                if (imem_gnt_i) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + DATA_WIDTH'(4);
                    state_d  = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid_i) begin
                    push    = 1'b1;
                    state_d = can_accept ? FETCH_REQ : FETCH_HOLD;
                end
            end
            FETCH_HOLD: begin
                if (instr_ready_i) state_d = FETCH_REQ;
            end
            FETCH_DISCARD: begin
                if (imem_rvalid_i) state_d = FETCH_REQ;
            end
            default: state_d = FETCH_BOOT;
        endcase

        // Redirect overrides the normal flow; an ungranted request simply re-aims.
        if (branch_take_i) begin
            pc_d = redirect_pc;
            push = 1'b0;
            case (state_q)
                FETCH_REQ:     state_d = imem_gnt_i ? FETCH_DISCARD : FETCH_REQ;
                FETCH_WAIT:    state_d = imem_rvalid_i ? FETCH_REQ : FETCH_DISCARD;
                // A response arriving alongside the redirect retires the outstanding fetch.
                FETCH_DISCARD: state_d = imem_rvalid_i ? FETCH_REQ : FETCH_DISCARD;
                default:       state_d = FETCH_REQ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= FETCH_BOOT;
            pc_q     <= RESET_VECTOR;
            req_pc_q <= RESET_VECTOR;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            flush_q  <= branch_take_i;
        end
    end

    assign imem_addr_o = {pc_q[DATA_WIDTH-1:2], 2'b00};
    assign flush_o     = flush_q;

    fetch_buffer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fetch_buffer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (branch_take_i),
        .push_i      (push),
        .push_data_i (imem_rdata_i),
        .push_pc_i   (req_pc_q),
        .can_accept_o(can_accept),
        .out_valid_o (instr_valid_o),
        .out_data_o  (instr_o),
        .out_pc_o    (instr_pc_o),
        .out_ready_i (instr_ready_i)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: fetch stream, back-pressure, redirects, PC wrap,
// misaligned targets (expectations follow FETCH_CTRL_MISALIGN_TRAP_EN) and mid-fetch reset.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        branch_take;
    logic [31:0] branch_target;
    logic        flush;
    logic        misalign;
    logic [31:0] misalign_tval;

    int pass_cnt  = 0;
    int check_cnt = 0;

    localparam logic [31:0] D0 = 32'h0000_0013;
    localparam logic [31:0] D4 = 32'h0040_0093;
    localparam logic [31:0] D8 = 32'h0080_0113;

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    localparam logic [31:0] MIS_ADDR = 32'h0000_0100;
    localparam logic [31:0] MIS_PULSE = 32'd1;
    localparam logic [31:0] MIS_TVAL = 32'h0000_0202;
`else
    localparam logic [31:0] MIS_ADDR = 32'h0000_0200;
    localparam logic [31:0] MIS_PULSE = 32'd0;
    localparam logic [31:0] MIS_TVAL = 32'h0000_0000;
`endif

    fetch_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .imem_req_o     (imem_req),
        .imem_addr_o    (imem_addr),
        .imem_gnt_i     (imem_gnt),
        .imem_rvalid_i  (imem_rvalid),
        .imem_rdata_i   (imem_rdata),
        .instr_valid_o  (instr_valid),
        .instr_o        (instr),
        .instr_pc_o     (instr_pc),
        .instr_ready_i  (instr_ready),
        .branch_take_i  (branch_take),
        .branch_target_i(branch_target),
        .flush_o        (flush),
        .misalign_o     (misalign),
        .misalign_tval_o(misalign_tval)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        instr_ready = 1'b0;
        branch_take = 1'b0;
        branch_target = '0;
        step();
        step();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_tval", misalign_tval, 32'h0);

        // cycle 0: BOOT
        rst = 1'b0;
        chk("boot_req", 32'(imem_req), 32'd0);
        step();
        // cycle 1: REQ @0, granted
        chk("c1_req", 32'(imem_req), 32'd1);
        chk("c1_addr", imem_addr, 32'h0);
        imem_gnt = 1'b1;
        step();
        // cycle 2: WAIT, response arrives
        chk("c2_req", 32'(imem_req), 32'd0);
        chk("c2_valid", 32'(instr_valid), 32'd0);
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = D0;
        instr_ready = 1'b1;
        step();
        // cycle 3: instruction visible, next request @4
        chk("c3_valid", 32'(instr_valid), 32'd1);
        chk("c3_instr", instr, D0);
        chk("c3_instr_pc", instr_pc, 32'h0);
        chk("c3_req", 32'(imem_req), 32'd1);
        chk("c3_addr", imem_addr, 32'h4);
        imem_rvalid = 1'b0;
        imem_gnt = 1'b1;
        step();
        // cycle 4: WAIT, buffer drained by decode
        chk("c4_valid", 32'(instr_valid), 32'd0);
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = D4;
        step();
        // cycle 5: pc4 held, decode stalls from here
        chk("c5_instr_pc", instr_pc, 32'h4);
        chk("c5_addr", imem_addr, 32'h8);
        imem_rvalid = 1'b0;
        imem_gnt = 1'b1;
        instr_ready = 1'b0;
        step();
        // cycle 6: WAIT, response for pc8 goes to the skid slot
        chk("c6_req", 32'(imem_req), 32'd0);
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = D8;
        step();
        imem_rvalid = 1'b0;
        for (int i = 7; i <= 9; i++) begin
            chk($sformatf("hold%0d_req", i), 32'(imem_req), 32'd0);
            chk($sformatf("hold%0d_valid", i), 32'(instr_valid), 32'd1);
            chk($sformatf("hold%0d_instr", i), instr, D4);
            chk($sformatf("hold%0d_instr_pc", i), instr_pc, 32'h4);
            step();
        end
        // cycle 10: decode resumes
        chk("c10_instr_pc", instr_pc, 32'h4);
        chk("c10_req", 32'(imem_req), 32'd0);
        instr_ready = 1'b1;
        step();
        // cycle 11: skid entry pc8 now in the buffer, request @C granted
        chk("c11_instr_pc", instr_pc, 32'h8);
        chk("c11_instr", instr, D8);
        chk("c11_addr", imem_addr, 32'hC);
        imem_gnt = 1'b1;
        step();
        // cycle 12: WAIT with no response, redirect to 0x200
        chk("c12_valid", 32'(instr_valid), 32'd0);
        imem_gnt = 1'b0;
        branch_take = 1'b1;
        branch_target = 32'h200;
        step();
        // cycle 13: DISCARD, stale response arrives
        chk("c13_flush", 32'(flush), 32'd1);
        chk("c13_req", 32'(imem_req), 32'd0);
        branch_take = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        // cycle 14: request at target, stale data never delivered
        chk("c14_flush", 32'(flush), 32'd0);
        chk("c14_valid", 32'(instr_valid), 32'd0);
        chk("c14_req", 32'(imem_req), 32'd1);
        chk("c14_addr", imem_addr, 32'h200);
        imem_rvalid = 1'b0;
        imem_gnt = 1'b1;
        step();
        // cycle 15: redirect coincident with rvalid
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_0BAD;
        branch_take = 1'b1;
        branch_target = 32'h300;
        step();
        // cycle 16: straight back to REQ at target; redirect coincident with gnt
        chk("c16_flush", 32'(flush), 32'd1);
        chk("c16_valid", 32'(instr_valid), 32'd0);
        chk("c16_req", 32'(imem_req), 32'd1);
        chk("c16_addr", imem_addr, 32'h300);
        imem_rvalid = 1'b0;
        imem_gnt = 1'b1;
        branch_target = 32'h400;
        step();
        // cycle 17: DISCARD
        chk("c17_flush", 32'(flush), 32'd1);
        chk("c17_req", 32'(imem_req), 32'd0);
        branch_take = 1'b0;
        imem_gnt = 1'b0;
        step();
        // cycle 18: still DISCARD until the old response returns
        chk("c18_req", 32'(imem_req), 32'd0);
        chk("c18_flush", 32'(flush), 32'd0);
        imem_rvalid = 1'b1;
        step();
        // cycle 19: request at 0x400; redirect ungranted request to top of memory
        chk("c19_req", 32'(imem_req), 32'd1);
        chk("c19_addr", imem_addr, 32'h400);
        chk("c19_valid", 32'(instr_valid), 32'd0);
        imem_rvalid = 1'b0;
        branch_take = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step();
        // cycle 20
        chk("c20_addr", imem_addr, 32'hFFFF_FFFC);
        chk("c20_req", 32'(imem_req), 32'd1);
        branch_take = 1'b0;
        imem_gnt = 1'b1;
        step();
        // cycle 21
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_0011;
        step();
        // cycle 22: PC wrapped to zero
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", instr, 32'h0000_0011);
        imem_rvalid = 1'b0;
        branch_take = 1'b1;
        branch_target = 32'h202;
        step();
        // cycle 23: misaligned target
        chk("mis_flush", 32'(flush), 32'd1);
        chk("mis_addr", imem_addr, MIS_ADDR);
        chk("mis_pulse", 32'(misalign), MIS_PULSE);
        chk("mis_tval", misalign_tval, MIS_TVAL);
        chk("mis_valid", 32'(instr_valid), 32'd0);
        branch_take = 1'b0;
        step();
        // cycle 24: pulse over, tval held
        chk("mis_pulse_end", 32'(misalign), 32'd0);
        chk("mis_tval_hold", misalign_tval, MIS_TVAL);
        imem_gnt = 1'b1;
        step();
        // cycle 25: reset in WAIT
        imem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_tval", misalign_tval, 32'h0);
        step();
        rst = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_0777;
        chk("late_boot_req", 32'(imem_req), 32'd0);
        step();
        // late response in BOOT is ignored
        chk("late_req", 32'(imem_req), 32'd1);
        chk("late_addr", imem_addr, 32'h0);
        chk("late_valid", 32'(instr_valid), 32'd0);
        imem_rvalid = 1'b0;
        step();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the rv32i core. It owns the PC and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake. It buffers one fetched instruction toward decode and applies redirects from the execute-stage branch_unit (take_o plus target). On redirect it flushes in-flight and buffered fetches and signals the pipeline.

Parameters:
DATA_WIDTH, 32, instruction/address width (from pkg_config)
RESET_VECTOR, 32'h0000_0000, first fetch address after reset
TRAP_VECTOR, 32'h0000_0100, fetch address on misaligned-target trap (MISALIGN_TRAP_EN only)

Ports:
clk_i  in  1  core clock
rst_i  in  1  reset; one clock, asynchronous, active-high
imem_req_o  out  1  fetch request valid
imem_addr_o  out  DATA_WIDTH  fetch address, word aligned
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response valid (earliest: cycle after gnt)
imem_rdata_i  in  DATA_WIDTH  fetched instruction
instr_valid_o  out  1  buffered instruction valid toward decode
instr_o  out  DATA_WIDTH  buffered instruction
instr_pc_o  out  DATA_WIDTH  PC of instr_o
instr_ready_i  in  1  decode accepts instr_o this cycle
branch_take_i  in  1  redirect request (branch_unit take_o)
branch_target_i  in  DATA_WIDTH  redirect target
flush_o  out  1  one-cycle pulse: kill younger pipeline stages
misalign_o  out  1  one-cycle trap pulse (0 when feature off)
misalign_tval_o  out  DATA_WIDTH  offending target, held until next trap (0 when feature off)

Behaviour:
- Reset (async, any state):
  - state=BOOT, pc=RESET_VECTOR.
  - imem_req_o=0, imem_addr_o=RESET_VECTOR.
  - instr_valid_o=0, instr_o=0, instr_pc_o=0.
  - flush_o=0, misalign_o=0, misalign_tval_o=0.
  - A reset mid-transaction drops any pending response; a late rvalid in BOOT is ignored.
- States: BOOT, REQ, WAIT, HOLD, DISCARD.
- BOOT -> REQ unconditionally after one cycle.
- REQ:
  - imem_req_o=1, imem_addr_o=pc; address is stable while req is high and gnt is low.
  - On gnt: latch req_pc=pc, pc<=pc+4 (mod 2^32; 0xFFFF_FFFC wraps to 0), go to WAIT.
- WAIT:
  - imem_req_o=0.
  - On rvalid, if buffer empty or instr_ready_i=1: load buffer (instr_o=rdata, instr_pc_o=req_pc, valid=1), go to REQ.
  - Otherwise: go to HOLD with rdata held in a second skid slot.
- HOLD:
  - No request issued.
  - On instr_ready_i: skid slot moves into the buffer, go to REQ.
- Buffer handshake:
  - instr_o and instr_pc_o are stable while instr_valid_o=1 and instr_ready_i=0.
  - Transfer occurs when instr_valid_o and instr_ready_i are both 1.
  - Latency: gnt at cycle N, rvalid at N+1 gives instr_valid_o at N+2.
- Redirect (branch_take_i=1), priority over everything except reset:
  - pc<=branch_target_i; buffer and skid slot invalidated at the same edge; flush_o=1 in the next cycle only.
  - From REQ without gnt: stay in REQ; the new address appears next cycle (ungranted request may change).
  - From REQ with gnt in the same cycle: go to DISCARD.
  - From WAIT with no rvalid: go to DISCARD.
  - From WAIT with rvalid in the same cycle: response dropped, go to REQ.
  - From HOLD: go to REQ.
  - From DISCARD: stay in DISCARD, pc updated.
  - From BOOT: go to REQ with the target.
- DISCARD: no request issued; on rvalid, drop the data and go to REQ.
- Back-to-back redirects: the last one wins; flush_o may stay high for consecutive cycles.
- Target alignment: imem_addr_o[1:0] is always 2'b00.

Optional Feature:
- Macro: FETCH_CTRL_MISALIGN_TRAP_EN.
- Defined: a redirect with target[1:0]!=0 does not go to that target. Instead:
  - pc<=TRAP_VECTOR and flush_o pulses.
  - misalign_o pulses one cycle (cycle after redirect); misalign_tval_o<=target.
  - State transitions are as for a normal redirect.
- Undefined: target[1:0] is forced to 00 silently; misalign_o and misalign_tval_o are tied to 0.

Decomposition:
- pkg_config gains:
  - typedef enum logic [2:0] fetch_state_t {FETCH_BOOT, FETCH_REQ, FETCH_WAIT, FETCH_HOLD, FETCH_DISCARD}.
  - Constants RESET_VECTOR and TRAP_VECTOR.
  - Reuses the existing DATA_WIDTH.
- One natural sub-module: fetch_buffer, a 2-entry skid buffer (data+pc) with valid/ready, flush input, and a "can accept" output used by the FSM.

Test Plan:
- Reset release, memory with gnt same cycle and rvalid +1 returning 0x00000013 -> addresses 0x0, 0x4, 0x8 issued; instr_valid_o at cycle 3 with instr_pc_o=0x0.
- instr_ready_i=0 for 5 cycles -> at most 2 instructions held, no req issued while full; instr_o stable; on ready, PCs 0x0, 0x4 delivered in order.
- branch_take_i=1, target=0x200, asserted in WAIT -> flush_o high exactly one cycle; the old response is dropped (never on instr_o); next imem_addr_o=0x200.
- Redirect coincident with rvalid -> data dropped, next request at the target, no DISCARD visit; redirect coincident with gnt -> DISCARD, then request at target.
- pc at 0xFFFF_FFFC, granted -> next address 0x0000_0000.
- With FETCH_CTRL_MISALIGN_TRAP_EN, target 0x202 -> misalign_o pulse, misalign_tval_o=0x202, next address 0x100. Without the macro -> next address 0x200, misalign_o=0.
